// File: rtl/mem_stage_mc.sv
// mem_stage_mc: multi-cycle memory stage between execute and writeback.
//
// Purpose:
//   Computes the combinational redirect PC (branch target, jump target or
//   fall-through). Drives a variable-latency data memory through a
//   level-request / done handshake and registers results toward writeback
//   behind a valid/ready pair. Detects misaligned accesses, aborts memory
//   requests after a watchdog timeout and stalls execute while busy.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      op handshake from execute
//   pc_add, imm_src, imm8_ext, imm11_ext, brch_cnd, alu_jump, alu_result
//                            redirect PC inputs (alu_result is also the address)
//   mem_read, mem_write, wdata, halt
//                            access type, store data, halt/dump request
//   next_pc                  combinational redirect PC
//   out_valid / out_ready    result handshake toward writeback
//   out_rdata, out_alu, out_err
//                            load data, registered alu_result, status code
//   stall                    in_valid & ~in_ready
//   mem_en, mem_wr, mem_addr, mem_wdata, mem_createdump
//                            memory request (level), write select, dump pulse
//   mem_done, mem_rdata, mem_err
//                            memory completion, read data, error flag

module mem_stage_mc #(
    parameter int DW        = 16,
    parameter int AW        = 16,
    parameter int TIMEOUT   = 64,
    parameter int ALIGN_CHK = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] pc_add,
    input  logic          imm_src,
    input  logic [AW-1:0] imm8_ext,
    input  logic [AW-1:0] imm11_ext,
    input  logic          brch_cnd,
    input  logic          alu_jump,
    input  logic [AW-1:0] alu_result,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [DW-1:0] wdata,
    input  logic          halt,
    output logic [AW-1:0] next_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_rdata,
    output logic [AW-1:0] out_alu,
    output logic [1:0]    out_err,
    output logic          stall,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_createdump,
    input  logic          mem_done,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_err
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [AW-1:0] ALIGN_MASK = AW'(DW / 8 - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt;
    logic          is_load;
    logic          halt_pend;
    logic          accept;
    logic          has_access;
    logic          misaligned;
    logic          start_req;
    logic          finish;
    logic          abort;
    logic [AW-1:0] sel_imm;

    // Redirect PC: the immediate is a halfword offset, the sum wraps at 2^AW.
    assign sel_imm = imm_src ? imm11_ext : imm8_ext;
    assign next_pc = alu_jump ? alu_result
                   : (brch_cnd ? pc_add + (sel_imm << 1) : pc_add);

    // A new op may only enter while no request is outstanding and the
    // result register is empty or being drained this cycle.
    assign in_ready   = (state == IDLE) & (~out_valid | out_ready);
    assign stall      = in_valid & ~in_ready;
    assign accept     = in_valid & in_ready;
    assign has_access = mem_read | mem_write;
    assign misaligned = (ALIGN_CHK != 0) && ((alu_result & ALIGN_MASK) != '0);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic. mem_done is tested before the watchdog so a
    // completion arriving on the last allowed cycle is still honoured.
    always_comb begin
        state_nxt = state;
        start_req = 1'b0;
        finish    = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (accept && has_access && !misaligned) begin
                    start_req = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_done) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_cnt == CNT_LAST) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: memory request registers, wait counter and the result
    // register. Ops without a memory request (no access or misaligned)
    // produce their result on the accept edge; memory ops produce it on
    // completion or abort. The dump pulse always coincides with the first
    // cycle the halt op's result is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en         <= 1'b0;
            mem_wr         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_createdump <= 1'b0;
            out_valid      <= 1'b0;
            out_rdata      <= '0;
            out_alu        <= '0;
            out_err        <= 2'b00;
            wait_cnt       <= '0;
            is_load        <= 1'b0;
            halt_pend      <= 1'b0;
        end else begin
            mem_createdump <= 1'b0;

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept && !start_req) begin
                out_valid      <= 1'b1;
                out_rdata      <= '0;
                out_alu        <= alu_result;
                out_err        <= has_access ? 2'b01 : 2'b00;
                mem_createdump <= halt;
            end

            if (start_req) begin
                mem_en    <= 1'b1;
                mem_wr    <= mem_write;
                mem_addr  <= alu_result;
                mem_wdata <= wdata;
                is_load   <= mem_read & ~mem_write;
                halt_pend <= halt;
                wait_cnt  <= '0;
            end

            if (state == WAIT) begin
                if (finish || abort) begin
                    mem_en         <= 1'b0;
                    out_valid      <= 1'b1;
                    out_alu        <= mem_addr;
                    out_rdata      <= (finish && is_load) ? mem_rdata : '0;
                    out_err        <= finish ? (mem_err ? 2'b11 : 2'b00) : 2'b10;
                    mem_createdump <= halt_pend;
                    wait_cnt       <= '0;
                end else begin
                    wait_cnt <= wait_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_mc.sv
// tb_mem_stage_mc: self-checking bench for mem_stage_mc.
//
// Purpose:
//   Drives directed and randomized ops, emulates a variable-latency memory
//   and compares every cycle against a transaction-level model that derives
//   each result's contents and arrival cycle from the op and the memory's
//   chosen latency. A few directed scenarios pin literal expectations.

module tb_mem_stage_mc;

    localparam int DW      = 16;
    localparam int AW      = 16;
    localparam int TIMEOUT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [AW-1:0] pc_add, imm8_ext, imm11_ext, alu_result, next_pc;
    logic          imm_src, brch_cnd, alu_jump, mem_read, mem_write, halt;
    logic [DW-1:0] wdata, out_rdata, mem_wdata, mem_rdata;
    logic          out_valid, out_ready, stall;
    logic [AW-1:0] out_alu, mem_addr;
    logic [1:0]    out_err;
    logic          mem_en, mem_wr, mem_createdump, mem_done, mem_err;

    mem_stage_mc #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT), .ALIGN_CHK(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_add(pc_add), .imm_src(imm_src), .imm8_ext(imm8_ext), .imm11_ext(imm11_ext),
        .brch_cnd(brch_cnd), .alu_jump(alu_jump), .alu_result(alu_result),
        .mem_read(mem_read), .mem_write(mem_write), .wdata(wdata), .halt(halt),
        .next_pc(next_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_alu(out_alu), .out_err(out_err), .stall(stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_createdump(mem_createdump),
        .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc, imm8, imm11, alu, wd;
        logic        imm_s, brch, jmp, rd, wr, hlt;
    } op_t;

    typedef struct {
        logic [15:0] rdata;
        logic [1:0]  err;
        logic [15:0] alu;
        logic        halt;
        logic        is_mem;
        int          acc;
        int          due;
    } res_t;

    typedef struct {
        int          lat;
        logic [15:0] data;
        logic        err;
    } mrsp_t;

    res_t  exp_q[$];
    mrsp_t mem_q[$];

    int tests_run = 0;
    int fails     = 0;
    int cyc       = 0;

    // Memory behaviour chosen for the next accepted access.
    int          nxt_lat  = 0;
    logic [15:0] nxt_data = '0;
    logic        nxt_err  = 1'b0;

    // Model of the outstanding memory request.
    logic        mem_act_v = 1'b0;
    int          mem_acc, mem_due;
    logic [15:0] mem_a, mem_d;
    logic        mem_w;

    // Observations for directed literal checks.
    int   last_lat, last_err, last_rdata;
    int   last_mem_lat, last_mem_err, last_mem_rdata;
    logic mem_en_seen = 1'b0;

    // Monitor scratch.
    res_t        r_pop, r_new;
    logic        mact, is_new, acc_any;
    logic        prev_valid = 1'b0, prev_ready = 1'b0;
    logic [15:0] prev_rdata, prev_alu;
    logic [1:0]  prev_err;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model_pc(input logic [15:0] pc, input logic [15:0] i8,
                                             input logic [15:0] i11, input logic is,
                                             input logic br, input logic jp, input logic [15:0] alu);
        int t;
        if (jp) return alu;
        if (!br) return pc;
        t = int'(pc) + 2 * int'(is ? i11 : i8);
        return t[15:0];
    endfunction

    function automatic op_t nop_op(input logic [15:0] alu);
        op_t o;
        o.pc = 16'h0100; o.imm8 = 16'h0004; o.imm11 = 16'h0008; o.alu = alu; o.wd = 16'h0000;
        o.imm_s = 1'b0; o.brch = 1'b0; o.jmp = 1'b0; o.rd = 1'b0; o.wr = 1'b0; o.hlt = 1'b0;
        return o;
    endfunction

    task automatic driveOp(input op_t o);
        pc_add = o.pc; imm8_ext = o.imm8; imm11_ext = o.imm11; imm_src = o.imm_s;
        brch_cnd = o.brch; alu_jump = o.jmp; alu_result = o.alu; wdata = o.wd;
        mem_read = o.rd; mem_write = o.wr; halt = o.hlt; in_valid = 1'b1;
    endtask

    task automatic clearOp();
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; halt = 1'b0;
    endtask

    // Present an op from posedge+1 and hold it until accepted; stalls counts
    // the cycles it was presented but refused.
    task automatic applyStimulus(input op_t o, output int stalls);
        logic got;
        got = 1'b0;
        stalls = 0;
        driveOp(o);
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (in_ready) begin got = 1'b1; break; end
            stalls++;
        end
        if (!got) begin
            tests_run++; fails++;
            $display("[TB] FAIL accept_timeout: got no accept expected accept within 200 cycles");
        end
        @(posedge clk); #1;
        clearOp();
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            tests_run++; fails++;
            $display("[TB] FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    // Memory emulation: once a request is seen, mem_done rises lat cycles
    // after mem_en first became visible and stays until the request drops.
    initial begin : responder
        mrsp_t cur;
        logic  active;
        int    cnt;
        active = 1'b0; cnt = 0; cur = '{1000, 16'h0, 1'b0};
        mem_done = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst || !mem_en) begin
                active = 1'b0; mem_done = 1'b0; mem_err = 1'b0;
                mem_rdata = 16'($urandom);
            end else begin
                if (!active) begin
                    active = 1'b1; cnt = 0;
                    if (mem_q.size() != 0) cur = mem_q.pop_front();
                    else cur = '{1000, 16'h0, 1'b0};
                end else begin
                    cnt++;
                end
                mem_done  = (cnt == cur.lat);
                mem_rdata = mem_done ? cur.data : 16'($urandom);
                mem_err   = mem_done ? cur.err : 1'($urandom);
            end
        end
    end

    // Compare process, sampling on the falling edge.
    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                exp_q.delete(); mem_q.delete();
                mem_act_v = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0;
            end else begin
                mact = mem_act_v && (cyc > mem_acc) && (cyc < mem_due);
                checkOutput("mem_en", mem_en, mact);
                if (mem_en) mem_en_seen = 1'b1;
                if (mact) begin
                    checkOutput("mem_addr", mem_addr, mem_a);
                    checkOutput("mem_wr", mem_wr, mem_w);
                    checkOutput("mem_wdata", mem_wdata, mem_d);
                end
                checkOutput("in_ready", in_ready, !mact && (!out_valid || out_ready));
                checkOutput("stall", stall, in_valid && !in_ready);
                if (in_valid)
                    checkOutput("next_pc", next_pc, model_pc(pc_add, imm8_ext, imm11_ext,
                                imm_src, brch_cnd, alu_jump, alu_result));

                is_new = out_valid && (!prev_valid || prev_ready);
                if (is_new) begin
                    if (exp_q.size() == 0) begin
                        tests_run++; fails++;
                        $display("[TB] FAIL out_unexpected: got out_valid expected no result");
                    end else begin
                        r_pop = exp_q.pop_front();
                        checkOutput("out_cycle", cyc, r_pop.due);
                        checkOutput("out_rdata", out_rdata, r_pop.rdata);
                        checkOutput("out_err", out_err, r_pop.err);
                        checkOutput("out_alu", out_alu, r_pop.alu);
                        checkOutput("dump_pulse", mem_createdump, r_pop.halt);
                        last_lat = cyc - r_pop.acc; last_err = out_err; last_rdata = out_rdata;
                        if (r_pop.is_mem) begin
                            last_mem_lat = last_lat; last_mem_err = out_err; last_mem_rdata = out_rdata;
                        end
                    end
                end else begin
                    checkOutput("dump_idle", mem_createdump, 1'b0);
                    if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                        tests_run++; fails++;
                        $display("[TB] FAIL out_missing: got no result expected one due at cycle %0d", exp_q[0].due);
                        void'(exp_q.pop_front());
                    end
                    if (prev_valid && !prev_ready) begin
                        checkOutput("hold_valid", out_valid, 1'b1);
                        checkOutput("hold_rdata", out_rdata, prev_rdata);
                        checkOutput("hold_err", out_err, prev_err);
                        checkOutput("hold_alu", out_alu, prev_alu);
                    end
                end
                if (mem_act_v && cyc >= mem_due) mem_act_v = 1'b0;

                if (in_valid && in_ready) begin
                    acc_any       = mem_read || mem_write;
                    r_new.alu     = alu_result;
                    r_new.halt    = halt;
                    r_new.acc     = cyc;
                    r_new.rdata   = '0;
                    r_new.is_mem  = 1'b0;
                    if (!acc_any) begin
                        r_new.err = 2'd0; r_new.due = cyc + 1;
                    end else if ((alu_result % (DW / 8)) != 0) begin
                        r_new.err = 2'd1; r_new.due = cyc + 1;
                    end else begin
                        r_new.is_mem = 1'b1;
                        mem_act_v = 1'b1; mem_acc = cyc;
                        mem_a = alu_result; mem_w = mem_write; mem_d = wdata;
                        mem_q.push_back('{nxt_lat, nxt_data, nxt_err});
                        if (nxt_lat <= TIMEOUT - 1) begin
                            r_new.due   = cyc + 2 + nxt_lat;
                            r_new.err   = nxt_err ? 2'd3 : 2'd0;
                            r_new.rdata = (mem_read && !mem_write) ? nxt_data : 16'h0;
                        end else begin
                            r_new.due = cyc + 1 + TIMEOUT;
                            r_new.err = 2'd2;
                        end
                        mem_due = r_new.due;
                    end
                    exp_q.push_back(r_new);
                end

                prev_valid = out_valid; prev_ready = out_ready;
                prev_rdata = out_rdata; prev_err = out_err; prev_alu = out_alu;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin : main
        op_t o;
        int  st;
        int  k;
        logic got;

        rst = 1'b1; out_ready = 1'b1;
        pc_add = '0; imm8_ext = '0; imm11_ext = '0; imm_src = 1'b0; brch_cnd = 1'b0;
        alu_jump = 1'b0; alu_result = '0; wdata = '0; clearOp();

        // Reset state.
        @(posedge clk); #1;
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_mem_en", mem_en, 1'b0);
        checkOutput("rst_mem_wr", mem_wr, 1'b0);
        checkOutput("rst_out_err", out_err, 2'b00);
        checkOutput("rst_out_rdata", out_rdata, 16'h0);
        checkOutput("rst_out_alu", out_alu, 16'h0);
        checkOutput("rst_dump", mem_createdump, 1'b0);
        checkOutput("rst_mem_addr", mem_addr, 16'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 16'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle_in_ready", in_ready, 1'b1);

        // Redirect PC literals (in_valid low, nothing is accepted).
        pc_add = 16'h0010; imm8_ext = 16'hFFFE; imm_src = 1'b0; brch_cnd = 1'b1; alu_jump = 1'b0;
        #1 checkOutput("pc_branch_back", next_pc, 16'h000C);
        alu_jump = 1'b1; alu_result = 16'h1234;
        #1 checkOutput("pc_jump", next_pc, 16'h1234);
        alu_jump = 1'b0; imm_src = 1'b1; imm11_ext = 16'h0005;
        #1 checkOutput("pc_imm11", next_pc, 16'h001A);
        pc_add = 16'hFFFE; imm_src = 1'b0; imm8_ext = 16'h0002;
        #1 checkOutput("pc_wrap", next_pc, 16'h0002);
        brch_cnd = 1'b0;
        #1 checkOutput("pc_fallthrough", next_pc, 16'hFFFE);
        @(posedge clk); #1;

        // Load with mem_done three cycles after mem_en, followed by a held op.
        nxt_lat = 3; nxt_data = 16'hBEEF; nxt_err = 1'b0;
        o = nop_op(16'h0100); o.rd = 1'b1;
        applyStimulus(o, st);
        applyStimulus(nop_op(16'h0042), st);
        checkOutput("load_stall_cycles", st, 4);
        waitIdle();
        checkOutput("load_latency", last_mem_lat, 5);
        checkOutput("load_rdata", last_mem_rdata, 16'hBEEF);
        checkOutput("load_err", last_mem_err, 0);

        // Misaligned store: no request, error next cycle.
        mem_en_seen = 1'b0;
        o = nop_op(16'h0003); o.wr = 1'b1; o.wd = 16'h5555;
        applyStimulus(o, st);
        waitIdle();
        checkOutput("misalign_no_req", mem_en_seen, 1'b0);
        checkOutput("misalign_err", last_err, 1);
        checkOutput("misalign_latency", last_lat, 1);

        // Memory never answers: abort, then the stage takes the next op.
        nxt_lat = 1000;
        o = nop_op(16'h0200); o.rd = 1'b1;
        applyStimulus(o, st);
        waitIdle();
        checkOutput("timeout_err", last_err, 2);
        checkOutput("timeout_latency", last_lat, 9);
        checkOutput("timeout_rdata", last_rdata, 0);
        applyStimulus(nop_op(16'h0300), st);
        waitIdle();
        checkOutput("after_timeout_stalls", st, 0);
        checkOutput("after_timeout_err", last_err, 0);

        // Done on the last allowed cycle wins over the watchdog.
        nxt_lat = TIMEOUT - 1; nxt_data = 16'h1357; nxt_err = 1'b0;
        o = nop_op(16'h0204); o.rd = 1'b1;
        applyStimulus(o, st);
        waitIdle();
        checkOutput("edge_done_err", last_mem_err, 0);
        checkOutput("edge_done_rdata", last_mem_rdata, 16'h1357);
        checkOutput("edge_done_latency", last_mem_lat, 9);

        // Memory error on a store; read+write with halt performs a write.
        nxt_lat = 1; nxt_data = 16'h7777; nxt_err = 1'b1;
        o = nop_op(16'h0206); o.wr = 1'b1; o.wd = 16'hA5A5;
        applyStimulus(o, st);
        waitIdle();
        checkOutput("mem_err_code", last_err, 3);
        checkOutput("mem_err_rdata", last_rdata, 0);
        nxt_lat = 0; nxt_data = 16'hAAAA; nxt_err = 1'b0;
        o = nop_op(16'h0208); o.rd = 1'b1; o.wr = 1'b1; o.wd = 16'h0F0F; o.hlt = 1'b1;
        applyStimulus(o, st);
        waitIdle();
        checkOutput("rw_rdata", last_rdata, 0);
        checkOutput("rw_latency", last_lat, 2);

        // Writeback back-pressure for three cycles.
        out_ready = 1'b0;
        applyStimulus(nop_op(16'h0AAA), st);
        driveOp(nop_op(16'h0BBB));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", in_ready, 1'b0);
            checkOutput("bp_valid", out_valid, 1'b1);
            checkOutput("bp_alu", out_alu, 16'h0AAA);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release", in_ready, 1'b1);
        @(posedge clk); #1;
        clearOp();
        waitIdle();

        // Reset while waiting on memory.
        nxt_lat = 1000;
        o = nop_op(16'h0400); o.rd = 1'b1;
        applyStimulus(o, st);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checkOutput("rst_wait_mem_en", mem_en, 1'b0);
        checkOutput("rst_wait_out_valid", out_valid, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(nop_op(16'h0500), st);
        waitIdle();
        checkOutput("after_rst_err", last_err, 0);

        // Randomized ops with random writeback back-pressure.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(3) == 0) begin
                out_ready = ($urandom_range(3) != 0);
                @(posedge clk); #1;
            end
            o.pc = 16'($urandom); o.imm8 = 16'($urandom); o.imm11 = 16'($urandom);
            o.imm_s = 1'($urandom); o.brch = 1'($urandom); o.jmp = ($urandom_range(3) == 0);
            o.alu = 16'($urandom); o.wd = 16'($urandom);
            if ($urandom_range(1) == 0) o.alu[0] = 1'b0;
            k = $urandom_range(7);
            o.rd = (k == 3 || k == 4 || k == 7);
            o.wr = (k == 5 || k == 6 || k == 7);
            o.hlt = ($urandom_range(9) == 0);
            nxt_lat  = ($urandom_range(9) == 0) ? TIMEOUT - 1 + $urandom_range(2) : $urandom_range(5);
            nxt_data = 16'($urandom);
            nxt_err  = ($urandom_range(9) == 0);
            out_ready = ($urandom_range(3) != 0);
            driveOp(o);
            got = 1'b0;
            for (int w = 0; w < 100; w++) begin
                @(negedge clk);
                if (in_ready) begin got = 1'b1; break; end
                @(posedge clk); #1;
                out_ready = ($urandom_range(3) != 0);
            end
            if (!got) begin
                tests_run++; fails++;
                $display("[TB] FAIL rand_accept: got no accept expected accept within 100 cycles");
            end
            @(posedge clk); #1;
            clearOp();
        end
        out_ready = 1'b1;
        waitIdle();
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage_mc.md
# mem_stage_mc

Parameterised, multi-cycle successor to the single-cycle memory stage. It sits between execute and writeback and computes the redirect PC: PC-relative branch target, ALU jump target or fall-through. It drives a variable-latency data memory through a level/done handshake and registers results toward writeback behind a valid/ready pair. It also adds misaligned-access detection, a watchdog timeout and stall generation that the single-cycle stage lacks.

## Interface
Parameters:
- DW, 16, data width (bits); must be 8, 16 or 32
- AW, 16, address/PC width
- TIMEOUT, 64, maximum cycles to wait for mem_done before aborting; must be ≥ 2
- ALIGN_CHK, 1, 1 = flag accesses not aligned to DW/8 bytes; 0 = pass all addresses

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; one clock, asynchronous and active-high
- in_valid  in  1  execute presents an op
- in_ready  out  1  stage can accept; in_valid & in_ready = accept
- pc_add  in  AW  PC+2 of the op
- imm_src  in  1  1 = imm11_ext, 0 = imm8_ext
- imm8_ext, imm11_ext  in  AW  sign-extended immediates
- brch_cnd  in  1  branch taken
- alu_jump  in  1  jump to alu_result
- alu_result  in  AW  ALU result / memory address
- mem_read, mem_write  in  1  access type
- wdata  in  DW  store data
- halt  in  1  halt op; requests memory dump
- next_pc  out  AW  combinational redirect PC
- out_valid  out  1  writeback result valid
- out_ready  in  1  writeback accepts
- out_rdata  out  DW  load data (0 for non-loads)
- out_alu  out  AW  registered alu_result
- out_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 memory error
- stall  out  1  = in_valid & ~in_ready
- mem_en, mem_wr  out  1  memory request (level), write select
- mem_addr  out  AW;  mem_wdata  out  DW
- mem_createdump  out  1  one-cycle dump pulse
- mem_done  in  1;  mem_rdata  in  DW;  mem_err  in  1

## Operation
- next_pc = alu_jump ? alu_result : (brch_cnd ? pc_add + (sel_imm << 1) : pc_add), modulo 2^AW; carry discarded.
- FSM IDLE/WAIT. in_ready = (state==IDLE) & (~out_valid | out_ready).
- Accept, no access (neither read nor write): next edge out_valid=1, out_rdata=0, out_err=00; state stays IDLE.
- Accept with access, misaligned when ALIGN_CHK=1 and alu_result mod (DW/8) ≠ 0: no memory request issued; next edge out_valid=1, out_err=01.
- Accept with aligned access: latch address/data/type; next edge state=WAIT, mem_en=1, mem_wr=mem_write. If both read and write are set, a write is performed and out_rdata=0.
- WAIT, mem_done=1: mem_en drops; state→IDLE; out_valid=1; out_rdata=mem_rdata for loads, else 0; out_err=11 if mem_err, else 00.
- WAIT: wait counter increments each cycle without mem_done. When the counter reaches TIMEOUT-1: abort, mem_en=0, out_err=10, state→IDLE. mem_done in the same cycle wins over timeout.
- Accept with halt: mem_createdump=1 for exactly one cycle starting on the next edge. Halt carrying an access: the dump pulse follows completion.
- out_valid holds until out_ready; all out_* are stable while out_valid & ~out_ready.

## Timing
- Reset (asynchronous): state=IDLE, mem_en=0, mem_wr=0, mem_createdump=0, out_valid=0, out_err=00, out_rdata=0, out_alu=0, counter=0. The reset value of mem_addr and mem_wdata is 0.
- Reset mid-WAIT: the request is abandoned; no result is produced.
- Latency: non-memory or misaligned op = 1 cycle; memory op = 2 + N cycles, where mem_done arrives N cycles after mem_en rises.
- Throughput: 1 op/cycle for non-memory ops with out_ready=1.
- next_pc has zero latency and is valid whenever in_valid=1.

## Test plan
- Branch: pc_add=0x0010, imm_src=0, imm8_ext=0xFFFE, brch_cnd=1 → next_pc=0x000C; with alu_jump=1, alu_result=0x1234 → next_pc=0x1234.
- Load, mem_done 3 cycles after mem_en, mem_rdata=0xBEEF → out_valid 5 cycles after accept, out_rdata=0xBEEF, out_err=00, stall high for 4 cycles.
- Store to 0x0003 (DW=16, ALIGN_CHK=1) → mem_en never rises, out_err=01 next cycle.
- mem_done never asserted (TIMEOUT=8) → abort at counter=7, out_err=10, then the next op is accepted.
- out_ready=0 for 3 cycles with out_valid=1 → in_ready=0 and outputs frozen; releasing out_ready accepts the next op that cycle.
- rst asserted mid-WAIT → mem_en=0 and out_valid=0 immediately, without waiting for clk.
